// File: rtl/flood_open_ctrl.sv
// Flood-open sequencer between player requests and the board cover store.
// Opens or flags one cell, flood-filling zero-count regions via a LIFO.
module flood_open_ctrl #(
    parameter int x_size       = 16,
    parameter int y_size       = 16,
    parameter int x_coord_bits = 4,
    parameter int y_coord_bits = 4,
    parameter int cnt_bits     = 9
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    input  logic                    req_open,
    input  logic                    req_flag,
    input  logic [x_coord_bits-1:0] req_x,
    input  logic [y_coord_bits-1:0] req_y,
    input  logic                    cover_init,
    input  logic [1:0]              cell_val,
    input  logic                    is_mine,
    input  logic [3:0]              mine_cnt,
    output logic                    flag,
    output logic                    open,
    output logic [x_coord_bits-1:0] x_coord,
    output logic [y_coord_bits-1:0] y_coord,
    output logic                    busy,
    output logic                    done,
    output logic                    hit_mine,
    output logic [cnt_bits-1:0]     opened_count
);

    localparam int depth = x_size * y_size;
    localparam int pw    = x_coord_bits + y_coord_bits;
    localparam logic [x_coord_bits-1:0] x_max = x_coord_bits'(x_size - 1);
    localparam logic [y_coord_bits-1:0] y_max = y_coord_bits'(y_size - 1);

    typedef enum logic [2:0] {
        IDLE, FLAG, PROBE, NEXT, SCAN, DONE
    } state_t;

    state_t state;

    logic [x_coord_bits-1:0] lx, cx, x_hold, nx;
    logic [y_coord_bits-1:0] ly, cy, y_hold, ny;
    logic [2:0]              nidx;
    logic [cnt_bits-1:0]     sp;
    logic [pw-1:0]           stk [depth];
    logic [pw-1:0]           wr_idx, rd_idx;

    logic dxm, dxp, dym, dyp;
    logic inb, probing, push, kill, accept;

    always_comb begin
        dxm = (nidx == 3'd0) || (nidx == 3'd3) || (nidx == 3'd5);
        dxp = (nidx == 3'd2) || (nidx == 3'd4) || (nidx == 3'd7);
        dym = (nidx <= 3'd2);
        dyp = (nidx >= 3'd5);
        inb = !(dxm && cx == '0) && !(dxp && cx == x_max) &&
              !(dym && cy == '0) && !(dyp && cy == y_max);
        nx  = cx + x_coord_bits'(dxp) - x_coord_bits'(dxm);
        ny  = cy + y_coord_bits'(dyp) - y_coord_bits'(dym);
    end

    // Coordinates are driven only while a real cell is addressed.
    always_comb begin
        x_coord = x_hold;
        y_coord = y_hold;
        probing = 1'b0;
        unique case (1'b1)
            state == FLAG: begin
                x_coord = lx;
                y_coord = ly;
            end
            state == PROBE: begin
                x_coord = lx;
                y_coord = ly;
                probing = 1'b1;
            end
            state == SCAN && inb: begin
                x_coord = nx;
                y_coord = ny;
                probing = 1'b1;
            end
            default: ;
        endcase
    end

    assign flag   = (state == FLAG);
    assign open   = probing && (cell_val == 2'b00);
    assign kill   = open && is_mine;
    assign push   = open && !is_mine && (mine_cnt == 4'd0);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign accept = req_valid && !cover_init && (req_open ^ req_flag);
    assign wr_idx = pw'(sp);
    assign rd_idx = pw'(sp - 1'b1);

    always_ff @(posedge clk) begin
        if (push)
            stk[wr_idx] <= {y_coord, x_coord};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            lx           <= '0;
            ly           <= '0;
            cx           <= '0;
            cy           <= '0;
            x_hold       <= '0;
            y_hold       <= '0;
            nidx         <= '0;
            sp           <= '0;
            hit_mine     <= 1'b0;
            opened_count <= '0;
        end else begin
            x_hold <= x_coord;
            y_hold <= y_coord;
            if (open)
                opened_count <= opened_count + 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        lx       <= req_x;
                        ly       <= req_y;
                        hit_mine <= 1'b0;
                        sp       <= '0;
                        state    <= req_flag ? FLAG : PROBE;
                    end
                end
                FLAG: state <= DONE;
                PROBE, SCAN: begin
                    // A mine aborts the fill; NEXT then sees an empty stack.
                    if (kill) begin
                        hit_mine <= 1'b1;
                        sp       <= '0;
                        state    <= NEXT;
                    end else begin
                        if (push)
                            sp <= sp + 1'b1;
                        if (state == PROBE || nidx == 3'd7)
                            state <= NEXT;
                        else
                            nidx <= nidx + 1'b1;
                    end
                end
                NEXT: begin
                    if (sp == '0) begin
                        state <= DONE;
                    end else begin
                        sp       <= sp - 1'b1;
                        {cy, cx} <= stk[rd_idx];
                        nidx     <= '0;
                        state    <= SCAN;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
